pad_window_gen: RTL and testbench
=================================

Name: pad_window_gen

Overview:
Streaming successor to the fixed-parameter padding buffer. It accepts a square image in raster order with run-time image size, filter size and pad mode. It then emits one padded KxK neighbourhood window per output pixel through a valid/ready handshake. It sits between the pixel source and the convolution MAC array. Padding is computed on read, never stored, so no pad region has to be cleared or rewritten.

Parameters:
DATA_WIDTH, 8, pixel width in bits
MAX_IMG, 7, largest supported image side; sets frame storage MAX_IMG*MAX_IMG
MAX_K, 5, largest filter side (odd); sets output window MAX_K*MAX_K
IDX_W, $clog2(MAX_IMG+1), width of size, row and column fields

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_img_size  in  IDX_W  image side N; sampled on the first accepted pixel of a frame
cfg_k5  in  1  0: 3x3 filter (P=1); 1: 5x5 filter (P=2); sampled with cfg_img_size
cfg_pad_mode  in  2  0 zero, 1 replicate, 2 mirror, 3 treated as zero; sampled with cfg_img_size
s_data  in  DATA_WIDTH  input pixel
s_valid  in  1  input pixel valid
s_ready  out  1  block can accept a pixel
m_window  out  MAX_K*MAX_K*DATA_WIDTH  window, element (i,j) at bit offset (i*MAX_K+j)*DATA_WIDTH
m_row  out  IDX_W  centre row of the current window
m_col  out  IDX_W  centre column of the current window
m_valid  out  1  window valid
m_ready  in  1  downstream accepts the window
frame_done  out  1  one-cycle pulse after the last window handshake

Behaviour:
- Reset: state IDLE; s_ready=0 during the reset cycle and 1 afterwards; m_valid=0, m_window=0, m_row=0, m_col=0, frame_done=0. Frame RAM contents are don't-care.
- States: IDLE, LOAD, EMIT.
- IDLE:
  - s_ready=1.
  - On s_valid: latch config, store the pixel at (0,0), go to LOAD. If N==1 after clamping, go directly to EMIT.
- LOAD:
  - s_ready=1; the pixel counter advances only on s_valid&&s_ready.
  - On the N*N-th pixel, go to EMIT. s_ready drops the cycle after.
- EMIT:
  - s_ready=0.
  - The first m_valid is asserted the cycle after the last pixel is accepted (1-cycle latency).
  - Windows are emitted in raster order (0,0)..(N-1,N-1), one per cycle while m_ready=1.
  - While m_valid=1 && m_ready=0, m_window, m_row and m_col are held stable.
  - On the handshake of window (N-1,N-1): next cycle m_valid=0, frame_done=1, state returns to IDLE.
- Window content:
  - Element (i,j), i,j in 0..K-1, reads source (r+i-P, c+j-P).
  - For K=3, the 3x3 window occupies positions 1..3 of the 5x5 grid; the outer ring is driven 0.
- Out-of-range coordinate x (per axis):
  - zero: the element is 0, for both axes.
  - replicate: clamp to 0..N-1.
  - mirror (reflect without edge repeat): x<0 maps to -x; x>N-1 maps to 2(N-1)-x.
- Config clamp:
  - N<3 is treated as 3; N>MAX_IMG as MAX_IMG.
  - Mirror with P>N-1 cannot occur after clamping.
- Config inputs are ignored outside the IDLE-to-LOAD sampling point.
- Reset asserted in any state, including mid-LOAD or mid-EMIT with a window pending: next cycle matches the reset values; the partial frame is discarded.
- Arithmetic: coordinates are computed signed at IDX_W+2 bits; no wrap is permitted.

Decomposition:
- Package pad_window_pkg:
  - pad_mode_e {PAD_ZERO, PAD_REPL, PAD_MIRR}
  - state_e {IDLE, LOAD, EMIT}
  - function clamp_size
- Sub-module pad_index_map: combinational; inputs signed coordinate, N, mode; outputs mapped index and a zero flag. Instantiated once per window row and once per window column (MAX_K of each).

Test Plan:
- 5x5 ramp (pixel = 5r+c+1), K=3, zero, m_ready=1 -> window (0,0) inner 3x3 = {0,0,0, 0,1,2, 0,6,7}; window (4,4) = {19,20,0, 24,25,0, 0,0,0}; 25 windows; frame_done 1 cycle after the 25th handshake.
- Same frame, replicate -> window (0,0) = {1,1,2, 1,1,2, 6,6,7}.
- 7x7 ramp (7r+c+1), K=5, mirror -> window (0,0) element (0,0) = 17, element (2,2) = 1, element (4,4) = 17; window (6,6) element (4,4) = 33.
- 6x6, K=5, replicate, m_ready low 3 cycles at window (0,3) -> m_window, m_row=0 and m_col=3 are stable for 4 cycles; exactly 36 windows; no window skipped or duplicated.
- Reset after 10 pixels of a 7x7 load, then a new 3x3 frame -> only 9 pixels are accepted, 9 windows are emitted, and the values come from the new frame only.
- cfg_img_size=2, cfg_pad_mode=3 -> clamped to N=3 with zero padding: s_ready drops after 9 pixels, 9 windows are emitted.

Source files
------------

// File: rtl/pad_window_pkg.sv
// Shared types and helpers for the padded window generator.
//   pad_mode_e  : decoded pad mode (code 3 folds onto PAD_ZERO)
//   state_e     : controller states
//   clamp_size  : limits the requested image side to MIN_IMG..max_n
//   decode_mode : maps the raw 2-bit cfg_pad_mode onto pad_mode_e
package pad_window_pkg;

  typedef enum logic [1:0] {
    PAD_ZERO = 2'd0,
    PAD_REPL = 2'd1,
    PAD_MIRR = 2'd2
  } pad_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam int unsigned MIN_IMG = 3;

  // Smallest legal side keeps a 5x5 mirror in range (P=2 <= N-1).
  function automatic int unsigned clamp_size(input int unsigned n, input int unsigned max_n);
    if (n < MIN_IMG) return MIN_IMG;
    if (n > max_n)   return max_n;
    return n;
  endfunction

  function automatic pad_mode_e decode_mode(input logic [1:0] code);
    case (code)
      2'd1:    return PAD_REPL;
      2'd2:    return PAD_MIRR;
      default: return PAD_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/pad_index_map.sv
// Maps one signed window coordinate onto a frame index for the active pad mode.
//   coord : signed source coordinate (may lie outside 0..size-1)
//   size  : image side N
//   mode  : pad mode
//   idx   : in-range index to read (forced to 0 when zero is set)
//   zero  : element must be driven 0 (zero padding, coordinate out of range)
module pad_index_map
  import pad_window_pkg::*;
#(
  parameter int unsigned IDX_W = 3
) (
  input  logic signed [IDX_W+1:0] coord,
  input  logic [IDX_W-1:0]        size,
  input  pad_mode_e               mode,
  output logic [IDX_W-1:0]        idx,
  output logic                    zero
);

  localparam int unsigned CW = IDX_W + 2;

  logic signed [CW-1:0] last;
  logic signed [CW-1:0] mapped;
  logic                 below;
  logic                 above;
  logic                 unused_high;

  assign last  = $signed({2'b00, size} - CW'(1));
  assign below = coord[CW-1];
  assign above = coord > last;

  // Reflection without edge repeat: -x below, 2(N-1)-x above.
  always_comb begin
    mapped = coord;
    zero   = 1'b0;
    case (mode)
      PAD_REPL: begin
        if (below)      mapped = '0;
        else if (above) mapped = last;
      end
      PAD_MIRR: begin
        if (below)      mapped = -coord;
        else if (above) mapped = last + last - coord;
      end
      default: zero = below || above;
    endcase
  end

  assign idx         = zero ? '0 : mapped[IDX_W-1:0];
  assign unused_high = ^mapped[CW-1:IDX_W];

endmodule

// File: rtl/pad_window_gen.sv
// Streaming padded-window generator: loads an NxN frame in raster order,
// then emits one KxK neighbourhood per pixel with padding computed on read.
//   clk, rst             : clock, synchronous active-high reset
//   cfg_img_size/k5/pad  : frame configuration, sampled on the first pixel
//   s_data/s_valid/s_ready : pixel input handshake
//   m_window/m_row/m_col/m_valid/m_ready : window output handshake
//   frame_done           : one-cycle pulse after the last window handshake
module pad_window_gen
  import pad_window_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_IMG    = 7,
  parameter int unsigned MAX_K      = 5,
  parameter int unsigned IDX_W      = $clog2(MAX_IMG + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IDX_W-1:0]                    cfg_img_size,
  input  logic                                cfg_k5,
  input  logic [1:0]                          cfg_pad_mode,
  input  logic [DATA_WIDTH-1:0]               s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [MAX_K*MAX_K*DATA_WIDTH-1:0]   m_window,
  output logic [IDX_W-1:0]                    m_row,
  output logic [IDX_W-1:0]                    m_col,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                frame_done
);

  localparam int unsigned DEPTH = MAX_IMG * MAX_IMG;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = IDX_W + 2;
  localparam int unsigned CTR   = MAX_K / 2;
  localparam int unsigned WW    = MAX_K * MAX_K * DATA_WIDTH;

  state_e                  state;
  logic [IDX_W-1:0]        n_q;
  logic                    k5_q;
  pad_mode_e               mode_q;
  logic [IDX_W-1:0]        wr_r;
  logic [IDX_W-1:0]        wr_c;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]        cfg_n_c;
  logic [IDX_W-1:0]        eff_n;
  logic                    eff_k5;
  pad_mode_e               eff_mode;
  logic [IDX_W-1:0]        n_last;
  logic                    last_pix;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [IDX_W-1:0]        sel_r;
  logic [IDX_W-1:0]        sel_c;
  logic                    last_win;
  logic [IDX_W-1:0]        row_idx  [MAX_K];
  logic [IDX_W-1:0]        col_idx  [MAX_K];
  logic [MAX_K-1:0]        row_zero;
  logic [MAX_K-1:0]        col_zero;
  logic [MAX_K-1:0]        act;
  logic [WW-1:0]           window_c;

  // Configuration is live from the inputs in IDLE so the first pixel's
  // decisions use it; afterwards the latched copy is authoritative.
  assign cfg_n_c  = IDX_W'(clamp_size(32'(cfg_img_size), MAX_IMG));
  assign eff_n    = (state == IDLE) ? cfg_n_c : n_q;
  assign eff_k5   = (state == IDLE) ? cfg_k5 : k5_q;
  assign eff_mode = (state == IDLE) ? decode_mode(cfg_pad_mode) : mode_q;
  assign n_last   = eff_n - IDX_W'(1);

  assign wr_en    = s_valid && s_ready;
  assign wr_addr  = AW'(wr_r) * AW'(MAX_IMG) + AW'(wr_c);
  assign last_pix = (wr_r == n_last) && (wr_c == n_last);
  assign last_win = (m_row == n_last) && (m_col == n_last);

  // Coordinates of the window to be loaded into the output register next.
  always_comb begin
    sel_r = '0;
    sel_c = '0;
    if (state == EMIT) begin
      if (m_col == n_last) begin
        sel_r = m_row + IDX_W'(1);
      end else begin
        sel_r = m_row;
        sel_c = m_col + IDX_W'(1);
      end
    end
  end

  // Per-axis index mapping; grid position g reads source offset g-CTR.
  for (genvar g = 0; g < MAX_K; g++) begin : g_axis
    localparam bit ACT3 = ((g + 1) >= CTR) && (g <= CTR + 1);
    localparam bit ACT5 = ((g + 2) >= CTR) && (g <= CTR + 2);

    logic signed [CW-1:0] row_coord;
    logic signed [CW-1:0] col_coord;

    assign row_coord = $signed({2'b00, sel_r} + CW'(g) - CW'(CTR));
    assign col_coord = $signed({2'b00, sel_c} + CW'(g) - CW'(CTR));
    assign act[g]    = eff_k5 ? ACT5 : ACT3;

    pad_index_map #(.IDX_W(IDX_W)) u_row_map (
      .coord (row_coord),
      .size  (eff_n),
      .mode  (eff_mode),
      .idx   (row_idx[g]),
      .zero  (row_zero[g])
    );

    pad_index_map #(.IDX_W(IDX_W)) u_col_map (
      .coord (col_coord),
      .size  (eff_n),
      .mode  (eff_mode),
      .idx   (col_idx[g]),
      .zero  (col_zero[g])
    );
  end

  // Window assembly; the pixel being written this cycle is forwarded so
  // window (0,0) can be registered on the same edge as the last pixel.
  for (genvar i = 0; i < MAX_K; i++) begin : g_win_row
    for (genvar j = 0; j < MAX_K; j++) begin : g_win_col
      logic [AW-1:0] rd_addr;
      assign rd_addr = AW'(row_idx[i]) * AW'(MAX_IMG) + AW'(col_idx[j]);
      assign window_c[(i*MAX_K+j)*DATA_WIDTH +: DATA_WIDTH] =
        (!act[i] || !act[j] || row_zero[i] || col_zero[j]) ? '0 :
        (wr_en && (rd_addr == wr_addr)) ? s_data : mem[rd_addr];
    end
  end

  // Frame storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= s_data;
  end

  // Controller with registered handshake and window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_window   <= '0;
      m_row      <= '0;
      m_col      <= '0;
      frame_done <= 1'b0;
      wr_r       <= '0;
      wr_c       <= '0;
      n_q        <= IDX_W'(MIN_IMG);
      k5_q       <= 1'b0;
      mode_q     <= PAD_ZERO;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          s_ready <= 1'b1;
          if (wr_en) begin
            if (state == IDLE) begin
              n_q    <= cfg_n_c;
              k5_q   <= cfg_k5;
              mode_q <= decode_mode(cfg_pad_mode);
            end
            if (last_pix) begin
              state    <= EMIT;
              s_ready  <= 1'b0;
              m_valid  <= 1'b1;
              m_window <= window_c;
              m_row    <= '0;
              m_col    <= '0;
              wr_r     <= '0;
              wr_c     <= '0;
            end else begin
              state <= LOAD;
              if (wr_c == n_last) begin
                wr_c <= '0;
                wr_r <= wr_r + IDX_W'(1);
              end else begin
                wr_c <= wr_c + IDX_W'(1);
              end
            end
          end
        end
        EMIT: begin
          s_ready <= 1'b0;
          if (m_valid && m_ready) begin
            if (last_win) begin
              state      <= IDLE;
              m_valid    <= 1'b0;
              frame_done <= 1'b1;
              s_ready    <= 1'b1;
            end else begin
              m_row    <= sel_r;
              m_col    <= sel_c;
              m_window <= window_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_window_gen.sv
// Bench for pad_window_gen: directed frames, a spec-level window model
// compared on every valid cycle, and literal window pins.
module tb_pad_window_gen;

  localparam int unsigned DW    = 8;
  localparam int unsigned MIMG  = 7;
  localparam int unsigned MK    = 5;
  localparam int unsigned IW    = 3;
  localparam int unsigned WW    = MK * MK * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [IW-1:0]   cfg_img_size;
  logic            cfg_k5;
  logic [1:0]      cfg_pad_mode;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic [WW-1:0]   m_window;
  logic [IW-1:0]   m_row;
  logic [IW-1:0]   m_col;
  logic            m_valid;
  logic            m_ready;
  logic            frame_done;

  pad_window_gen #(.DATA_WIDTH(DW), .MAX_IMG(MIMG), .MAX_K(MK), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_img_size (cfg_img_size),
    .cfg_k5       (cfg_k5),
    .cfg_pad_mode (cfg_pad_mode),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_window     (m_window),
    .m_row        (m_row),
    .m_col        (m_col),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Model state for the frame in flight.
  int mdl_n    = 3;
  bit mdl_k5   = 1'b0;
  int mdl_mode = 0;
  int img [0:6][0:6];

  int exp_idx   = 0;
  bit fd_next   = 1'b0;
  int win_count = 0;
  logic [WW-1:0] cap_win [0:48];

  int lit_zero00 [9] = '{0, 0, 0, 0, 1, 2, 0, 6, 7};
  int lit_zero44 [9] = '{19, 20, 0, 24, 25, 0, 0, 0, 0};
  int lit_repl00 [9] = '{1, 1, 2, 1, 1, 2, 6, 6, 7};
  int lit_clmp00 [9] = '{0, 0, 0, 0, 1, 2, 0, 4, 5};

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int elem(input logic [WW-1:0] w, input int i, input int j);
    return int'(w[(i*MK+j)*DW +: DW]);
  endfunction

  // One axis of the padding rule; z set when the element must be zero.
  function automatic int map_ax(input int x, input int n, input int mode, output bit z);
    z = 1'b0;
    if (x >= 0 && x < n) return x;
    case (mode)
      1:       return (x < 0) ? 0 : n - 1;
      2:       return (x < 0) ? -x : 2 * (n - 1) - x;
      default: begin z = 1'b1; return 0; end
    endcase
  endfunction

  function automatic logic [WW-1:0] model_win(input int r, input int c);
    logic [WW-1:0] w;
    int p, y, x, gi, gj;
    bit zy, zx;
    w = '0;
    p = mdl_k5 ? 2 : 1;
    for (int i = 0; i <= 2 * p; i++) begin
      for (int j = 0; j <= 2 * p; j++) begin
        y  = map_ax(r + i - p, mdl_n, mdl_mode, zy);
        x  = map_ax(c + j - p, mdl_n, mdl_mode, zx);
        gi = i + 2 - p;
        gj = j + 2 - p;
        if (!zy && !zx) w[(gi*MK+gj)*DW +: DW] = DW'(img[y][x]);
      end
    end
    return w;
  endfunction

  // Compare process: every unreset cycle checks frame_done, and every
  // valid cycle checks the window against the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_idx = 0;
      fd_next = 1'b0;
    end else begin
      chk("frame_done", WW'(frame_done), WW'(fd_next));
      fd_next = 1'b0;
      if (m_valid) begin
        if (exp_idx >= mdl_n * mdl_n) begin
          chk("extra_window", WW'(1), WW'(0));
        end else begin
          chk("m_row", WW'(m_row), WW'(exp_idx / mdl_n));
          chk("m_col", WW'(m_col), WW'(exp_idx % mdl_n));
          chk($sformatf("window_%0d", exp_idx), m_window,
              model_win(exp_idx / mdl_n, exp_idx % mdl_n));
          if (m_ready) begin
            cap_win[exp_idx] = m_window;
            win_count++;
            if (exp_idx == mdl_n * mdl_n - 1) begin
              fd_next = 1'b1;
              exp_idx = 0;
            end else begin
              exp_idx++;
            end
          end
        end
      end
    end
  end

  // Entry/exit point of every task: #1 after a rising edge.
  task automatic send_frame(input int size_cfg, input bit k5, input int mode,
                            input int base, input int npix);
    int n, cnt;
    n = (size_cfg < 3) ? 3 : (size_cfg > 7) ? 7 : size_cfg;
    mdl_n = n; mdl_k5 = k5; mdl_mode = (mode == 3) ? 0 : mode;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        img[r][c] = (r < n && c < n) ? base + n * r + c + 1 : 0;
    win_count = 0;
    for (int p = 0; p < npix; p++) begin
      s_valid = 1'b1;
      s_data  = DW'(img[p / n][p % n]);
      if (p == 0) begin
        cfg_img_size = IW'(size_cfg);
        cfg_k5       = k5;
        cfg_pad_mode = 2'(mode);
      end else begin
        cfg_img_size = IW'($urandom_range(0, 7));
        cfg_k5       = 1'($urandom_range(0, 1));
        cfg_pad_mode = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      cnt = 0;
      while (!s_ready && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      if (!s_ready) chk("s_ready_timeout", WW'(s_ready), WW'(1));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (npix == n * n) begin
      @(negedge clk);
      chk("s_ready_after_last", WW'(s_ready), WW'(0));
      chk("first_m_valid", WW'(m_valid), WW'(1));
      @(posedge clk); #1;
    end
  endtask

  int dwell;
  logic [WW-1:0] held;

  task automatic run_emit(input bit stall);
    int stalls;
    bit got;
    stalls = 0; dwell = 0; got = 1'b0; held = '0;
    for (int t = 0; t < 300 && !got; t++) begin
      if (stall && m_valid && m_row == 0 && m_col == 3 && stalls < 3) begin
        m_ready = 1'b0;
        stalls++;
      end else begin
        m_ready = 1'b1;
      end
      if (m_valid && m_row == 0 && m_col == 3) begin
        dwell++;
        if (dwell == 1) held = m_window;
        else if (stall) chk("held_window", m_window, held);
      end
      @(negedge clk);
      if (frame_done) got = 1'b1;
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    if (!got) chk("frame_done_timeout", WW'(0), WW'(1));
    chk("window_count", WW'(win_count), WW'(mdl_n * mdl_n));
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_s_ready"}, WW'(s_ready), WW'(0));
    chk({tag, "_m_valid"}, WW'(m_valid), WW'(0));
    chk({tag, "_m_window"}, m_window, WW'(0));
    chk({tag, "_m_row_col"}, WW'({m_row, m_col}), WW'(0));
    chk({tag, "_frame_done"}, WW'(frame_done), WW'(0));
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_img_size = '0; cfg_k5 = 1'b0; cfg_pad_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_and_check("por");
    @(posedge clk); #1;
    chk("s_ready_post_reset", WW'(s_ready), WW'(1));

    // 5x5 ramp, 3x3, zero padding
    send_frame(5, 1'b0, 0, 0, 25);
    run_emit(1'b0);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("zero00_%0d", k), WW'(elem(cap_win[0], 1 + k / 3, 1 + k % 3)), WW'(lit_zero00[k]));
      chk($sformatf("zero44_%0d", k), WW'(elem(cap_win[24], 1 + k / 3, 1 + k % 3)), WW'(lit_zero44[k]));
    end

    // same frame, replicate
    send_frame(5, 1'b0, 1, 0, 25);
    run_emit(1'b0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("repl00_%0d", k), WW'(elem(cap_win[0], 1 + k / 3, 1 + k % 3)), WW'(lit_repl00[k]));

    // 7x7 ramp, 5x5, mirror
    send_frame(7, 1'b1, 2, 0, 49);
    run_emit(1'b0);
    chk("mirr00_e00", WW'(elem(cap_win[0], 0, 0)), WW'(17));
    chk("mirr00_e22", WW'(elem(cap_win[0], 2, 2)), WW'(1));
    chk("mirr00_e44", WW'(elem(cap_win[0], 4, 4)), WW'(17));
    chk("mirr66_e44", WW'(elem(cap_win[48], 4, 4)), WW'(33));

    // 6x6, 5x5, replicate, backpressure at window (0,3)
    send_frame(6, 1'b1, 1, 0, 36);
    run_emit(1'b1);
    chk("stall_dwell", WW'(dwell), WW'(4));

    // abort a 7x7 load after 10 pixels, then a fresh 3x3 frame
    send_frame(7, 1'b1, 2, 0, 10);
    reset_and_check("midload");
    send_frame(3, 1'b0, 0, 100, 9);
    run_emit(1'b0);
    chk("new_frame_centre", WW'(elem(cap_win[4], 2, 2)), WW'(105));
    chk("new_frame_corner", WW'(elem(cap_win[8], 2, 2)), WW'(109));

    // size 2 with pad code 3 -> N=3, zero padding
    send_frame(2, 1'b0, 3, 0, 9);
    run_emit(1'b0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("clamp00_%0d", k), WW'(elem(cap_win[0], 1 + k / 3, 1 + k % 3)), WW'(lit_clmp00[k]));

    // reset with a window pending under backpressure
    m_ready = 1'b0;
    send_frame(4, 1'b1, 2, 0, 16);
    @(posedge clk); #1;
    chk("pending_valid", WW'(m_valid), WW'(1));
    reset_and_check("midemit");
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_emit_reset", WW'(m_valid), WW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
